serial_add_sub: RTL
===================

Name: serial_add_sub

Overview:
- Bit-serial WIDTH-bit adder/subtractor built around a 1-bit add/sub cell plus a carry/borrow flip-flop.
- Loads two parallel operands on a start handshake and processes one bit per clock, LSB first.
- Presents the parallel result with carry/borrow and a one-cycle done pulse.
- Sits as the sequencing stage that feeds the team's 1-bit add_sub cell and consumes its sum/difference and carry outputs, trading area for latency.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); latched with start.
- a  input  WIDTH  operand A, latched with start.
- b  input  WIDTH  operand B, latched with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result/cout/ovf valid.
- result  output  WIDTH  sum or difference (mod 2^WIDTH).
- cout  output  1  add: carry out of MSB; sub: borrow (1 when a < b unsigned).
- ovf  output  1  signed overflow (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, ports named clk and rst. rst dominates every other input.
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0, state=IDLE, bit counter=0, carry FF=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch a into shift register SA, latch b into SB, latch mode, clear bit counter.
  - Carry FF is initialised to mode: 0 for add, 1 for subtract, giving two's complement with b inverted.
  - Go to RUN. start=0: stay in IDLE.
- RUN: each edge processes bit i = counter.
  - Cell inputs: x = SA[0], y = SB[0] XOR mode, cin = carry FF.
  - s = x^y^cin shifts into result MSB, result shifts right.
  - carry FF <= majority(x, y, cin). SA and SB shift right. Counter increments.
  - On the edge processing i = WIDTH-1, go to DONE.
- DONE:
  - done=1 for exactly this cycle.
  - cout = carry FF for add, ~carry FF for subtract.
  - Next edge goes to IDLE unconditionally; start is ignored in this cycle.
- Latency: if start is sampled at edge E0, done is high during the cycle after edge E0+WIDTH. Back-to-back throughput is one op per WIDTH+2 cycles.
- Output hold:
  - result, cout and ovf hold their final values after DONE until the next accepted start.
  - result bits change during RUN; consumers must qualify with done.
  - cout and ovf update only on entry to DONE.
- start, mode, a and b are don't-care while busy=1. Operand changes during RUN do not affect the operation in flight.
- Reset mid-operation (any state): next edge, all outputs and state return to reset values and the partial result is discarded. No done pulse is produced for the aborted op.
- Wrap-around: result is modulo 2^WIDTH. Add 0xFF+0x01 gives result=0x00, cout=1.

Optional Feature:
- Macro OVERFLOW_DETECT_EN.
- Defined:
  - An extra register captures the carry into the MSB during bit WIDTH-1.
  - On entry to DONE, ovf = carry_into_MSB XOR carry_out_of_MSB, i.e. two's-complement signed overflow for both add and subtract.
  - ovf follows the same hold and reset rules as cout.
- Not defined: the ovf port remains present, tied to 0, and no extra register is instantiated.

Test Plan (WIDTH=8):
- Add 0x35+0x4A, mode=0 -> result=0x7F, cout=0, done high exactly during the cycle after start edge +8, busy high for 9 cycles.
- Add 0xFF+0x01 -> result=0x00, cout=1; then sub 0x10-0x01 -> result=0x0F, cout=0.
- Sub 0x01-0x02, mode=1 -> result=0xFF, cout=1 (borrow); sub 0x00-0x00 -> result=0x00, cout=0.
- start held high continuously with operands changed mid-RUN -> first op completes with its latched operands; next op accepted only from IDLE, i.e. 2 cycles after done.
- rst pulsed at bit 3 of 0xAA+0x55 -> next edge busy=0, result=0, no done pulse; a fresh 0x0F+0x01 then yields 0x10.
- OVERFLOW_DETECT_EN defined: 0x7F+0x01 -> result=0x80, ovf=1; 0x80-0x01 -> 0x7F, ovf=1; 0x05+0x03 -> ovf=0. Macro undefined: ovf=0 for all cases.

Source files
------------

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
//
// Bit-serial WIDTH-bit adder/subtractor. Two parallel operands are captured on
// a start request and combined one bit per clock, LSB first, through a 1-bit
// add/sub cell and a carry/borrow flip-flop. Subtraction is a + ~b + 1: the
// b bit is inverted in the cell and the carry FF is seeded with 1.
//
// Latency: start sampled at edge E0 -> done high in the cycle after E0+WIDTH.
// Throughput: one operation per WIDTH+2 cycles (IDLE -> RUN x WIDTH -> DONE).
//
// Configuration macro:
//   OVERFLOW_DETECT_EN  when defined, ovf reports two's-complement signed
//                       overflow (carry into MSB XOR carry out of MSB).
//                       When undefined, ovf is tied to 0.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset, dominates all other inputs
//   start   in   begin an operation (sampled only in IDLE)
//   mode    in   0 = a+b, 1 = a-b (captured with start)
//   a, b    in   WIDTH-bit operands (captured with start)
//   busy    out  high whenever the FSM is not in IDLE
//   done    out  one-cycle pulse; result/cout/ovf valid
//   result  out  sum/difference mod 2^WIDTH (bits move during RUN)
//   cout    out  add: carry out; sub: borrow (1 when a < b unsigned)
//   ovf     out  signed overflow (see macro above)
// -----------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic             mode_q;
  logic [CW-1:0]    cnt;
  logic             carry;

  // 1-bit add/sub cell
  logic cell_x, cell_y, cell_s, cell_c;

  assign cell_x = sa[0];
  assign cell_y = sb[0] ^ mode_q;
  assign cell_s = cell_x ^ cell_y ^ carry;
  assign cell_c = (cell_x & cell_y) | (cell_x & carry) | (cell_y & carry);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and status outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand shifters, carry FF, result shifter, cout
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      mode_q <= 1'b0;
      cnt    <= '0;
      carry  <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            mode_q <= mode;
            cnt    <= '0;
            carry  <= mode;  // +1 of the two's complement for subtract
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          result <= {cell_s, result[WIDTH-1:1]};
          carry  <= cell_c;
          cnt    <= cnt + 1'b1;
          // Final bit: carry out of the MSB is known now; borrow is its inverse.
          if (cnt == LAST) cout <= cell_c ^ mode_q;
        end
        default: ;
      endcase
    end
  end

`ifdef OVERFLOW_DETECT_EN
  // While processing bit WIDTH-1 the carry FF holds the carry into the MSB and
  // the cell produces the carry out of it; their XOR is signed overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == RUN && cnt == LAST) begin
      ovf <= carry ^ cell_c;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
